truth_table_scan: RTL

Sequential stimulus/capture stage that sits directly upstream of a small combinational gate network (N_IN inputs, 1 output). After a start pulse it walks every input combination in ascending binary order and drives it onto the network. It waits a programmable settle time, then samples the network output, building the full truth table as a 2^N_IN-bit word. The finished table is offered to downstream logic through a valid/ready handshake, together with a ones count and tautology/contradiction flags.

---
 rtl/truth_table_pkg.sv | 26 ++
 rtl/tt_settle_timer.sv | 30 +++
 rtl/truth_table_scan.sv | 122 ++++++++++++
 3 files changed

// File: rtl/truth_table_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | truth_table_pkg : shared types, constants and helpers for the      |
// |                   truth-table scan stage                           |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
package truth_table_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRIVE  = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_VALID  = 2'd3
    } tt_state_t;

    localparam int c_n_in_min   = 1;
    localparam int c_n_in_max   = 6;
    localparam int c_settle_min = 0;
    localparam int c_settle_max = 15;

    function automatic int tt_width(input int n);
        return 1 << n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tt_settle_timer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tt_settle_timer : 4-bit loadable down-counter, saturates at zero   |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
module tt_settle_timer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [3:0] value,
    input  logic       dec,
    output logic       expired
);

    logic [3:0] r_count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count <= 4'd0;
        end else if (load) begin
            r_count <= value;
        end else if (dec && (r_count != 4'd0)) begin
            r_count <= r_count - 4'd1;
        end
    end

    assign expired = (r_count == 4'd0);

endmodule
`default_nettype wire

// File: rtl/truth_table_scan.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | truth_table_scan : walks all input combinations of a small gate    |
// |                    network and captures its full truth table       |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
module truth_table_scan
    import truth_table_pkg::*;
#(
    parameter int N_IN   = 3,
    parameter int SETTLE = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    output logic                      busy,
    output logic [N_IN-1:0]           dut_in,
    input  logic                      dut_out,
    output logic [tt_width(N_IN)-1:0] table_out,
    output logic [N_IN:0]             ones_count,
    output logic                      all_ones,
    output logic                      all_zeros,
    output logic                      table_valid,
    input  logic                      table_ready
);

    localparam int            c_width  = tt_width(N_IN);
    localparam int            c_last_i = c_width - 1;
    localparam logic [N_IN:0] c_last   = c_last_i[N_IN:0];
    localparam logic [N_IN:0] c_full   = c_width[N_IN:0];
    localparam logic [N_IN:0] c_one    = {{N_IN{1'b0}}, 1'b1};
    localparam logic [3:0]    c_settle = 4'(SETTLE);

    tt_state_t           r_state;
    logic [N_IN:0]       r_idx;
    logic [c_width-1:0]  r_table;
    logic [N_IN:0]       r_ones;
    logic                r_busy;
    logic                r_valid;

    logic                w_is_last;
    logic                w_load;
    logic                w_dec;
    logic                w_expired;

    // idx carries one spare bit so the last-combination compare never wraps
    assign w_is_last = (r_idx == c_last);
    assign w_load    = ((r_state == ST_IDLE) && start) ||
                       ((r_state == ST_SAMPLE) && !w_is_last);
    assign w_dec     = (r_state == ST_DRIVE);

    tt_settle_timer u_settle_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (w_load),
        .value   (c_settle),
        .dec     (w_dec),
        .expired (w_expired)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_table <= '0;
            r_ones  <= '0;
            r_busy  <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_table <= '0;
                        r_ones  <= '0;
                        r_idx   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= ST_DRIVE;
                    end
                end
                ST_DRIVE: begin
                    if (w_expired) begin
                        r_state <= ST_SAMPLE;
                    end
                end
                ST_SAMPLE: begin
                    r_table[r_idx[N_IN-1:0]] <= dut_out;
                    r_ones <= r_ones + {{N_IN{1'b0}}, dut_out};
                    if (w_is_last) begin
                        r_busy  <= 1'b0;
                        r_valid <= 1'b1;
                        r_state <= ST_VALID;
                    end else begin
                        r_idx   <= r_idx + c_one;
                        r_state <= ST_DRIVE;
                    end
                end
                ST_VALID: begin
                    // start in the handshake cycle is deliberately dropped
                    if (table_ready) begin
                        r_valid <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_valid <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy        = r_busy;
    assign dut_in      = r_idx[N_IN-1:0];
    assign table_out   = r_table;
    assign ones_count  = r_ones;
    assign table_valid = r_valid;
    assign all_ones    = (r_ones == c_full);
    assign all_zeros   = (r_ones == '0);

endmodule
`default_nettype wire
